decoder24_pulse: RTL and testbench
==================================

// Module: decoder24_pulse
// PURPOSE
//  - Registered 2-to-4 one-hot decoder, the receive side of the 4-to-2 encoder path.
//  - Accepts a 2-bit code on a valid/ready handshake.
//  - Drives the matching one-hot line for HOLD_CYC cycles, then a GAP_CYC all-zero gap.
//  - Sits between the encoder/control logic and the one-hot consumers (LED or select lines).
// PARAMETERS
//  - HOLD_CYC  default 4 : cycles the one-hot output is held; legal range 1..2**CNT_W
//  - GAP_CYC   default 1 : all-zero cycles after the hold; legal range 0..2**CNT_W
//  - CNT_W     default 8 : width of the internal down-counter
// PORTS
//  - clk       in   1 : single clock, rising edge
//  - rst_n     in   1 : asynchronous, active-low reset
//  - y         in   2 : code to decode; sampled only on acceptance
//  - in_valid  in   1 : y is valid
//  - in_ready  out  1 : block can accept a code this cycle
//  - a         out  4 : registered one-hot output, a = 4'b0001 << code
//  - busy      out  1 : state != IDLE
//  - done      out  1 : 1-cycle pulse in the last cycle of a hold+gap sequence
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset rst_n is asynchronous and active-low.
//  - Reset values: state=IDLE, a=0, busy=0, done=0, counter=0, skid buffer empty.
//    Reset asserted mid-sequence aborts it immediately: a=0 with no wait for a clock edge.
//  - Acceptance: in_valid && in_ready at a rising edge. y is ignored at every other time.
//  - FSM states:
//    - IDLE -> HOLD on accept.
//      Next cycle a = one-hot(y); counter loads HOLD_CYC-1.
//    - HOLD: a held constant. Counter decrements each cycle.
//      At counter==0: go to GAP if GAP_CYC>0, counter loads GAP_CYC-1; else end the sequence.
//    - GAP: a=0. Counter decrements each cycle; at counter==0, end the sequence.
//    - End of sequence: done=1 in that last cycle; next state IDLE (see SKID_BUF_EN).
//  - Latency:
//    - a goes one-hot exactly 1 cycle after acceptance.
//    - The one-hot value lasts exactly HOLD_CYC cycles; a=0 for exactly GAP_CYC cycles after it.
//  - in_ready is decoded from registered state only; there is no combinational path from in_valid.
//  - done is registered-state derived. It is high only in the final HOLD cycle (GAP_CYC=0) or the final GAP cycle.
//  - Counter never wraps: it is reloaded on every state entry. CNT_W must hold max(HOLD_CYC,GAP_CYC)-1.
//  - in_valid held high continuously: one code is accepted per sequence; no code is skipped or repeated.
// CONFIGURATION
//  - Macro: SKID_BUF_EN
//  - Undefined:
//    - in_ready = (state==IDLE).
//    - One IDLE cycle always separates consecutive sequences.
//  - Defined:
//    - Adds a one-entry code buffer; in_ready = !buf_full, including during HOLD/GAP.
//    - Accept while busy: code is stored in the buffer.
//    - End of sequence with buf_full: go directly to HOLD with the buffered code (no IDLE cycle); buffer empties.
//    - End of sequence with buffer empty and an accept in the same cycle: go directly to HOLD with the new y (bypass).
//    - Accept in IDLE with buffer empty: goes straight to HOLD, as when undefined.
//    - Reset empties the buffer.
// TESTING
//  (HOLD_CYC=4, GAP_CYC=1 unless stated)
//  1. Reset released, in_valid=0 -> a=0, in_ready=1, busy=0, done=0 indefinitely.
//  2. Accept y=0,1,2,3 in turn, each from IDLE -> a = 0001/0010/0100/1000 for exactly 4 cycles each,
//     then 1 zero cycle with done=1, then IDLE.
//  3. y changes 2->3 while busy, in_valid=1 (macro off) -> in_ready=0 and a stays 0100;
//     y=3 is accepted only in the next IDLE cycle.
//  4. rst_n driven low in the 2nd HOLD cycle of y=3 -> a=0 and busy=0 asynchronously;
//     after release, the next accept (y=1) produces a=0010 normally.
//  5. GAP_CYC=0, HOLD_CYC=1, y=2 -> a=0100 for exactly one cycle with done=1 in that same cycle.
//  6. SKID_BUF_EN defined: accept y=1 then y=3 during HOLD -> a=0010 x4, 0000 x1, 1000 x4, with no IDLE cycle between.

Source files
------------

// File: rtl/decoder24_pulse.sv
// Registered 2-to-4 one-hot decoder that holds each code for HOLD_CYC cycles, then a GAP_CYC gap.
// Optional one-entry code buffer for back-to-back sequences: define SKID_BUF_EN.
module decoder24_pulse #(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] y,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] a,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  localparam logic [CNT_W-1:0] HoldLd = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GapLd  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
  localparam bit               HasGap = (GAP_CYC > 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       a_q, a_d;
  logic             accept, seq_end;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

`ifdef SKID_BUF_EN
  logic       buf_full_q, buf_full_d;
  logic [1:0] buf_code_q, buf_code_d;
  assign in_ready = !buf_full_q;
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign accept  = in_valid && in_ready;
  assign busy    = (state_q != StIdle);
  // Last cycle of the sequence: final GAP cycle, or final HOLD cycle when there is no gap.
  assign seq_end = (cnt_q == '0) &&
                   ((state_q == StGap) || ((state_q == StHold) && !HasGap));
  assign done    = seq_end;
  assign a       = a_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
`ifdef SKID_BUF_EN
    buf_full_d = buf_full_q;
    buf_code_d = buf_code_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          a_d     = onehot(y);
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (HasGap) begin
          state_d = StGap;
          cnt_d   = GapLd;
          a_d     = '0;
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (seq_end) begin
      state_d = StIdle;
      cnt_d   = '0;
      a_d     = '0;
`ifdef SKID_BUF_EN
      if (buf_full_q) begin
        state_d    = StHold;
        cnt_d      = HoldLd;
        a_d        = onehot(buf_code_q);
        buf_full_d = 1'b0;
      end else if (accept) begin
        // Bypass: buffer empty, new code goes straight into the next hold.
        state_d = StHold;
        cnt_d   = HoldLd;
        a_d     = onehot(y);
      end
`endif
    end

`ifdef SKID_BUF_EN
    if (accept && busy && !seq_end) begin
      buf_full_d = 1'b1;
      buf_code_d = y;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
    end
  end

`ifdef SKID_BUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_code_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_code_q <= buf_code_d;
    end
  end
`endif

endmodule

// File: tb/tb_decoder24_pulse.sv
// Table-driven bench for decoder24_pulse: default instance (HOLD=4, GAP=1) and HOLD=1, GAP=0.
module tb_decoder24_pulse;

`ifdef SKID_BUF_EN
  localparam logic BR = 1'b1;  // in_ready while busy with an empty buffer
`else
  localparam logic BR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] y, y1;
  logic       in_valid, in_valid1;
  logic       in_ready, in_ready1;
  logic [3:0] a, a1;
  logic       busy, busy1, done, done1;

  int errors = 0;
  int checks = 0;

  decoder24_pulse dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .y        (y),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .busy     (busy),
    .done     (done)
  );

  decoder24_pulse #(
    .HOLD_CYC (1),
    .GAP_CYC  (0),
    .CNT_W    (8)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .y        (y1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .a        (a1),
    .busy     (busy1),
    .done     (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] y;
    logic [3:0] a;
    logic       rdy;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic v, input logic [1:0] yy, input logic [3:0] ea,
                               input logic rdy, input logic bz, input logic dn);
    vec_t t;
    t.v = v; t.y = yy; t.a = ea; t.rdy = rdy; t.busy = bz; t.done = dn;
    vq.push_back(t);
  endfunction

  // Each vector: outputs expected during that cycle, inputs driven for the edge ending it.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d].a", tag, i), 32'(a), 32'(vq[i].a));
      chk($sformatf("%s[%0d].rdy", tag, i), 32'(in_ready), 32'(vq[i].rdy));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vq[i].busy));
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(vq[i].done));
      in_valid = vq[i].v;
      y        = vq[i].y;
    end
    vq.delete();
  endtask

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0; in_valid = 1'b0; y = 2'd0; in_valid1 = 1'b0; y1 = 2'd0;
    #12;
    chk("rst.a", 32'(a), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Idle after reset with no traffic.
    for (int i = 0; i < 5; i++) push(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_vecs("idle");

    // Each code from IDLE: 4 hold cycles, 1 gap cycle with done, then IDLE.
    for (int c = 0; c < 4; c++) begin
      oh = 4'b0001 << c;
      push(1'b1, 2'(c), 4'h0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) push(1'b0, 2'd0, oh, BR, 1'b1, 1'b0);
      push(1'b0, 2'd0, 4'h0, BR, 1'b1, 1'b1);
    end
    push(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_vecs("codes");

`ifndef SKID_BUF_EN
    // y changes to 3 while busy with in_valid high: accepted only in the next IDLE cycle.
    push(1'b1, 2'd2, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push(1'b1, 2'd3, 4'b0100, 1'b0, 1'b1, 1'b0);
    push(1'b1, 2'd3, 4'h0, 1'b0, 1'b1, 1'b1);
    push(1'b1, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push(1'b0, 2'd0, 4'b1000, 1'b0, 1'b1, 1'b0);
    push(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
    push(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_vecs("nobuf");
`else
    // y=1 accepted, y=3 buffered during HOLD, then played with no IDLE cycle between.
    push(1'b1, 2'd1, 4'h0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 2'd3, 4'b0010, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) push(1'b0, 2'd0, 4'b0010, 1'b0, 1'b1, 1'b0);
    push(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) push(1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 1'b0);
    push(1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b1);
    push(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_vecs("skid");
`endif

    // Reset in the 2nd HOLD cycle of y=3 clears outputs without a clock edge.
    push(1'b1, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 2'd0, 4'b1000, BR, 1'b1, 1'b0);
    push(1'b0, 2'd0, 4'b1000, BR, 1'b1, 1'b0);
    run_vecs("prerst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.a", 32'(a), 32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 2'd1, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push(1'b0, 2'd0, 4'b0010, BR, 1'b1, 1'b0);
    push(1'b0, 2'd0, 4'h0, BR, 1'b1, 1'b1);
    push(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_vecs("postrst");

    // HOLD_CYC=1, GAP_CYC=0: single one-hot cycle with done in that same cycle.
    @(negedge clk);
    chk("h1.idle.a", 32'(a1), 32'h0);
    chk("h1.idle.rdy", 32'(in_ready1), 32'h1);
    in_valid1 = 1'b1; y1 = 2'd2;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("h1.a", 32'(a1), 32'h4);
    chk("h1.done", 32'(done1), 32'h1);
    chk("h1.busy", 32'(busy1), 32'h1);
    chk("h1.rdy", 32'(in_ready1), 32'(BR));
    @(negedge clk);
    chk("h1.after.a", 32'(a1), 32'h0);
    chk("h1.after.done", 32'(done1), 32'h0);
    chk("h1.after.busy", 32'(busy1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
